bus_txn_arbiter: RTL and testbench
==================================

Name: bus_txn_arbiter

Overview:
- Shares the single transaction-level bus master (start / ready / clear_ready handshake into the Wishbone bridge) between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Grants one requester and registers its address, data, size and write-enable.
- Sequences the start and clear_ready pulses toward the bridge, then returns read data and a one-cycle done pulse to the granted requester.
- Sits between the core pipeline and the bus bridge.

Parameters:
- DATA_WIDTH, 32, width of write/read data on every port.
- ADDR_WIDTH, 32, width of transaction address on every port.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low
- req0_i  in  1  port 0 request, level; held with fields stable until done0_o
- addr0_i  in  ADDR_WIDTH  port 0 address
- wdata0_i  in  DATA_WIDTH  port 0 write data
- size0_i  in  2  port 0 size (0 byte, 1 half, 2 word)
- we0_i  in  1  port 0 write enable
- rdata0_o  out  DATA_WIDTH  port 0 read data, valid with done0_o, held until next port 0 completion
- done0_o  out  1  port 0 completion pulse
- req1_i, addr1_i, wdata1_i, size1_i, we1_i, rdata1_o, done1_o: same as port 0, for port 1
- txn_addr_o  out  ADDR_WIDTH  registered address to bridge
- txn_data_o  out  DATA_WIDTH  registered write data to bridge
- txn_size_o  out  2  registered size
- txn_we_o  out  1  registered write enable
- txn_start_o  out  1  start pulse to bridge
- txn_clear_ready_o  out  1  clear-ready pulse to bridge
- txn_ready_i  in  1  bridge completion flag (sticky until cleared)
- txn_data_i  in  DATA_WIDTH  bridge read data
- grant_o  out  1  index of current/last granted port

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, CLEAR.
- IDLE: if any req is high, pick a winner by the arbitration rule. On that edge, register the winner's addr/wdata/size/we into txn_* and set grant_o. Go to ISSUE. With no request, stay in IDLE.
- ISSUE: txn_start_o=1 for exactly one cycle. Go to WAIT.
- WAIT: txn_start_o=0. Hold txn_* stable, because the bridge passes the address and data combinationally to Wishbone. On txn_ready_i=1, capture txn_data_i into the granted port's rdata register and go to CLEAR.
- WAIT has no timeout; the arbiter waits indefinitely.
- CLEAR: txn_clear_ready_o=1 and done<grant>_o=1 for one cycle. rdata is already valid this cycle. Go to IDLE.
- The requester deasserts req on the clock edge where it samples done high, so it is not re-granted. A req still high in the IDLE cycle that follows is a new request.
- Writes also capture txn_data_i into rdata. The value is meaningless (the bridge returns its stale register) and requesters ignore it.
- Minimum latency with a zero-wait slave acking the first stb cycle:
  - req seen in IDLE at cycle 0;
  - start at cycle 1;
  - stb and ack at cycle 2;
  - txn_ready_i at cycle 3;
  - done at cycle 4.
- Back-to-back transactions are spaced 4 cycles minimum; IDLE always lasts at least one cycle.
- Default arbitration is fixed priority: port 0 wins when both ports request.
- A request arriving mid-transaction waits; it is never dropped.
- Reset values (async, rst_ni=0): state IDLE; txn_start_o, txn_clear_ready_o, done0_o, done1_o, grant_o, txn_we_o = 0; txn_addr_o, txn_data_o, txn_size_o, rdata0_o, rdata1_o = 0.
- Reset mid-transaction: returns to IDLE immediately; no done is issued. The top level drives the bridge reset from the same source, so no bridge state is orphaned.
- Invalid size 3 is forwarded unchanged; the bridge maps it to word.

Optional Feature:
- Macro BUS_TXN_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-grant register, reset 0, gives priority to the port not granted last, applied only when both ports request in IDLE. A sole requester always wins.
- Undefined: fixed priority, port 0 over port 1; the last-grant register is not built.

Decomposition:
- Package bus_txn_pkg:
  - state enum (IDLE, ISSUE, WAIT, CLEAR);
  - size encodings SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2;
  - port index constants PORT_IF=0, PORT_LSU=1.
- Sub-module txn_arb_pick: combinational two-way picker with inputs req0, req1 and last_grant, outputs valid and grant_idx. It contains the macro-dependent logic; the FSM stays in bus_txn_arbiter.

Test Plan:
- Single read on port 0 (addr 0x100, size 2), bridge returns 0xCAFEBABE with txn_ready_i at cycle 3 → txn_start_o high for 1 cycle at cycle 1; done0_o at cycle 4; rdata0_o=0xCAFEBABE; txn_clear_ready_o coincident with done0_o.
- Port 1 write (addr 0x2000, wdata 0x12345678, size 0, we 1), with ready delayed 10 cycles → txn_addr_o, txn_data_o, txn_size_o, txn_we_o stable across all WAIT cycles; start pulses once; done1_o after ready.
- Both ports requesting continuously for 4 transactions: without the macro, grants are 0,0,0,0; with BUS_TXN_ARB_RR_EN, grants are 0,1,0,1.
- Port 1 raises req during a port 0 transaction → port 1 granted in the IDLE after port 0's done; no request lost; no overlapping start pulses.
- rst_ni asserted during WAIT → all outputs 0 asynchronously, without waiting for a clock edge; after release, a fresh port 0 request completes normally in 4 cycles.
- txn_ready_i held high in the cycle after CLEAR (bridge clear lag) → arbiter in IDLE ignores it and does not emit a spurious done.

Source files
------------

// File: rtl/bus_txn_pkg.sv
// Shared types and constants for the two-port transaction arbiter in front of the bus bridge.
// Used by bus_txn_arbiter and txn_arb_pick.
package bus_txn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_LSU = 1'b1;

endpackage

// File: rtl/txn_arb_pick.sv
// Combinational two-way requester picker for bus_txn_arbiter.
// BUS_TXN_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module txn_arb_pick
    import bus_txn_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic grant_idx
);

    assign valid = req0 | req1;

`ifdef BUS_TXN_ARB_RR_EN
    always_comb begin
        if (req0 && req1) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = req1 ? PORT_LSU : PORT_IF;
        end
    end
`else
    // History is irrelevant under fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    assign grant_idx = (!req0 && req1) ? PORT_LSU : PORT_IF;
`endif

endmodule

// File: rtl/bus_txn_arbiter.sv
// Shares one transaction-level bridge master between instruction fetch (port 0) and LSU (port 1).
// Arbitration policy comes from txn_arb_pick; BUS_TXN_ARB_RR_EN enables round-robin.
module bus_txn_arbiter
    import bus_txn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [1:0]            size0_i,
    input  logic                  we0_i,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    output logic                  done0_o,

    input  logic                  req1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    input  logic [1:0]            size1_i,
    input  logic                  we1_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic                  done1_o,

    output logic [ADDR_WIDTH-1:0] txn_addr_o,
    output logic [DATA_WIDTH-1:0] txn_data_o,
    output logic [1:0]            txn_size_o,
    output logic                  txn_we_o,
    output logic                  txn_start_o,
    output logic                  txn_clear_ready_o,
    input  logic                  txn_ready_i,
    input  logic [DATA_WIDTH-1:0] txn_data_i,

    output logic                  grant_o
);

    state_t state_q, state_d;
    logic   pick_valid;
    logic   pick_idx;

    // grant_o doubles as the last-grant history for round-robin.
    txn_arb_pick u_pick (
        .req0       (req0_i),
        .req1       (req1_i),
        .last_grant (grant_o),
        .valid      (pick_valid),
        .grant_idx  (pick_idx)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid)  state_d = ISSUE;
            ISSUE:                    state_d = WAIT;
            WAIT:    if (txn_ready_i) state_d = CLEAR;
            CLEAR:                    state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Bridge forwards txn_* combinationally, so they only change at grant time.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_o    <= PORT_IF;
            txn_addr_o <= '0;
            txn_data_o <= '0;
            txn_size_o <= SIZE_BYTE;
            txn_we_o   <= 1'b0;
            rdata0_o   <= '0;
            rdata1_o   <= '0;
        end else begin
            if (state_q == IDLE && pick_valid) begin
                grant_o    <= pick_idx;
                txn_addr_o <= (pick_idx == PORT_LSU) ? addr1_i  : addr0_i;
                txn_data_o <= (pick_idx == PORT_LSU) ? wdata1_i : wdata0_i;
                txn_size_o <= (pick_idx == PORT_LSU) ? size1_i  : size0_i;
                txn_we_o   <= (pick_idx == PORT_LSU) ? we1_i    : we0_i;
            end
            if (state_q == WAIT && txn_ready_i) begin
                if (grant_o == PORT_LSU) begin
                    rdata1_o <= txn_data_i;
                end else begin
                    rdata0_o <= txn_data_i;
                end
            end
        end
    end

    assign txn_start_o       = (state_q == ISSUE);
    assign txn_clear_ready_o = (state_q == CLEAR);
    assign done0_o           = (state_q == CLEAR) && (grant_o == PORT_IF);
    assign done1_o           = (state_q == CLEAR) && (grant_o == PORT_LSU);

endmodule

// File: tb/tb_bus_txn_arbiter.sv
// Scoreboard bench for bus_txn_arbiter: requester drivers, a bridge model and a decoupled monitor.
// Expected grant order follows BUS_TXN_ARB_RR_EN when defined.
module tb_bus_txn_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  size;
        logic        we;
        logic        chk_rd;
    } txn_t;

    logic        clk_i;
    logic        rst_ni;
    logic        req   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [1:0]  size  [2];
    logic        we    [2];
    logic [31:0] rdata [2];
    logic        done  [2];
    logic [31:0] txn_addr_o;
    logic [31:0] txn_data_o;
    logic [1:0]  txn_size_o;
    logic        txn_we_o;
    logic        txn_start_o;
    logic        txn_clear_ready_o;
    logic        txn_ready_i;
    logic [31:0] txn_data_i;
    logic        grant_o;

    int total = 0;
    int bad   = 0;

    txn_t        rq [2][$];
    txn_t        sb [2][$];
    txn_t        cur [2];
    logic        eg [$];
    logic [31:0] mem [logic [31:0]];
    int          bridge_extra = 0;
    logic        bridge_lag   = 1'b0;

    bus_txn_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req0_i            (req[0]),
        .addr0_i           (addr[0]),
        .wdata0_i          (wdata[0]),
        .size0_i           (size[0]),
        .we0_i             (we[0]),
        .rdata0_o          (rdata[0]),
        .done0_o           (done[0]),
        .req1_i            (req[1]),
        .addr1_i           (addr[1]),
        .wdata1_i          (wdata[1]),
        .size1_i           (size[1]),
        .we1_i             (we[1]),
        .rdata1_o          (rdata[1]),
        .done1_o           (done[1]),
        .txn_addr_o        (txn_addr_o),
        .txn_data_o        (txn_data_o),
        .txn_size_o        (txn_size_o),
        .txn_we_o          (txn_we_o),
        .txn_start_o       (txn_start_o),
        .txn_clear_ready_o (txn_clear_ready_o),
        .txn_ready_i       (txn_ready_i),
        .txn_data_i        (txn_data_i),
        .grant_o           (grant_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                                input logic w, input logic [31:0] rd, input logic chk);
        txn_t t;
        t.addr = a; t.wdata = wd; t.size = sz; t.we = w; t.rdata = rd; t.chk_rd = chk;
        return t;
    endfunction

    task automatic drive(input int p, input txn_t t);
        req[p] = 1'b1; addr[p] = t.addr; wdata[p] = t.wdata; size[p] = t.size; we[p] = t.we;
        sb[p].push_back(t);
        cur[p] = t;
    endtask

    // Requester: holds req until done; keeps it high into IDLE when another item is queued.
    task automatic requester(input int p);
        int wc = 0;
        forever begin
            @(posedge clk_i); #1;
            if (!req[p]) begin
                if (rst_ni && rq[p].size() > 0) begin
                    drive(p, rq[p].pop_front());
                    wc = 0;
                end
            end else if (!rst_ni) begin
                req[p] = 1'b0;
                void'(sb[p].pop_back());
            end else if (done[p]) begin
                wc = 0;
                if (rq[p].size() > 0) drive(p, rq[p].pop_front());
                else req[p] = 1'b0;
            end else if (++wc > 200) begin
                total++; bad++;
                $display("FAIL req%0d_timeout: no done after %0d cycles, required done", p, wc);
                req[p] = 1'b0;
                void'(sb[p].pop_back());
            end
        end
    endtask

    initial requester(0);
    initial requester(1);

    // Bridge model: ready rises two cycles after start (+extra), sticky until clear_ready.
    initial begin
        int   cnt = 0;
        logic lag_pend = 1'b0;
        txn_ready_i = 1'b0;
        txn_data_i  = 32'h0;
        forever begin
            @(posedge clk_i); #1;
            if (!rst_ni) begin
                cnt = 0; lag_pend = 1'b0; txn_ready_i = 1'b0;
            end else begin
                if (lag_pend) begin
                    txn_ready_i = 1'b0; lag_pend = 1'b0;
                end
                if (txn_clear_ready_o) begin
                    if (bridge_lag) lag_pend = 1'b1;
                    else txn_ready_i = 1'b0;
                end
                if (txn_start_o) begin
                    cnt = 2 + bridge_extra;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        txn_ready_i = 1'b1;
                        if (!txn_we_o && mem.exists(txn_addr_o)) txn_data_i = mem[txn_addr_o];
                    end
                end
            end
        end
    end

    // Monitor: pops scoreboard on done, checks grant order, start pulse shape and field stability.
    initial begin
        logic        busy = 1'b0;
        logic        prev_start = 1'b0;
        logic        g;
        logic [31:0] s_addr, s_data;
        logic [2:0]  s_ctl;
        txn_t        t;
        forever begin
            @(posedge clk_i); #2;
            if (!rst_ni) begin
                busy = 1'b0; prev_start = 1'b0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (done[p]) begin
                        if (sb[p].size() == 0) begin
                            total++; bad++;
                            $display("FAIL spurious_done%0d: got done=1 expected no pending request", p);
                        end else begin
                            t = sb[p].pop_front();
                            if (t.chk_rd) check($sformatf("rdata%0d", p), rdata[p], t.rdata);
                        end
                    end
                end
                check("clear_with_done", 32'(txn_clear_ready_o), 32'(done[0] | done[1]));
                if (txn_start_o) begin
                    check("start_single_cycle", 32'(prev_start), 32'(0));
                    check("start_no_overlap", 32'(busy), 32'(0));
                    busy = 1'b1;
                    if (eg.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_start: got start with grant=%0d expected none", grant_o);
                    end else begin
                        g = eg.pop_front();
                        check("grant", 32'(grant_o), 32'(g));
                        check("txn_addr", txn_addr_o, cur[g].addr);
                        check("txn_data", txn_data_o, cur[g].wdata);
                        check("txn_size_we", 32'({txn_size_o, txn_we_o}), 32'({cur[g].size, cur[g].we}));
                    end
                    s_addr = txn_addr_o; s_data = txn_data_o; s_ctl = {txn_size_o, txn_we_o};
                end else if (busy) begin
                    check("hold_addr", txn_addr_o, s_addr);
                    check("hold_data", txn_data_o, s_data);
                    check("hold_ctl", 32'({txn_size_o, txn_we_o}), 32'(s_ctl));
                    if (txn_clear_ready_o) busy = 1'b0;
                end
                prev_start = txn_start_o;
            end
        end
    end

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk_i); #2;
            ok = rq[0].size() == 0 && rq[1].size() == 0 && sb[0].size() == 0 && sb[1].size() == 0
                 && !req[0] && !req[1] && eg.size() == 0;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_idle: pending work remains (grants left %0d), required drained", eg.size());
            eg.delete();
        end
        #1;
    endtask

    task automatic wait_start(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk_i); #2;
            ok = txn_start_o;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_start: got no start pulse, required one");
        end
    endtask

    // Minimum-latency profile: start at cycle 1, done/clear at cycle 4 relative to first req cycle.
    task automatic lat_check(input int p, input logic [31:0] rd);
        logic ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk_i); #2;
            ok = req[p];
        end
        check("lat_req_seen", 32'(ok), 32'(1));
        check("lat_c0_start", 32'(txn_start_o), 32'(0));
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk_i); #2;
            check($sformatf("lat_c%0d_start", c), 32'(txn_start_o), 32'(c == 1));
            check($sformatf("lat_c%0d_done", c), 32'(done[p]), 32'(c == 4));
            check($sformatf("lat_c%0d_clear", c), 32'(txn_clear_ready_o), 32'(c == 4));
        end
        check("lat_rdata", rdata[p], rd);
    endtask

    initial begin
        logic ok;
        rst_ni = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; addr[p] = '0; wdata[p] = '0; size[p] = '0; we[p] = 1'b0;
        end

        repeat (2) @(posedge clk_i);
        #2;
        check("rst_start", 32'(txn_start_o), 32'(0));
        check("rst_clear", 32'(txn_clear_ready_o), 32'(0));
        check("rst_done", 32'({done[0], done[1]}), 32'(0));
        check("rst_grant", 32'(grant_o), 32'(0));
        check("rst_txn_addr", txn_addr_o, 32'h0);
        check("rst_rdata", rdata[0] | rdata[1], 32'h0);
        #1 rst_ni = 1'b1;
        wait_idle();

        // Single port 0 read at minimum latency.
        mem[32'h100] = 32'hCAFEBABE;
        eg.push_back(1'b0);
        rq[0].push_back(mk(32'h100, 32'h0, 2'd2, 1'b0, 32'hCAFEBABE, 1'b1));
        lat_check(0, 32'hCAFEBABE);
        wait_idle();

        // Port 1 byte write with a slow bridge.
        bridge_extra = 10;
        eg.push_back(1'b1);
        rq[1].push_back(mk(32'h2000, 32'h12345678, 2'd0, 1'b1, 32'h0, 1'b0));
        wait_idle();
        bridge_extra = 0;

        // Both ports requesting continuously, four transactions each.
        for (int i = 0; i < 4; i++) begin
            mem[32'h400 + 32'(4 * i)] = 32'hA0000000 + 32'(i);
            mem[32'h500 + 32'(4 * i)] = 32'hB0000000 + 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            rq[0].push_back(mk(32'h400 + 32'(4 * i), 32'h0, 2'd2, 1'b0, 32'hA0000000 + 32'(i), 1'b1));
            rq[1].push_back(mk(32'h500 + 32'(4 * i), 32'h0, 2'd1, 1'b0, 32'hB0000000 + 32'(i), 1'b1));
        end
`ifdef BUS_TXN_ARB_RR_EN
        for (int i = 0; i < 8; i++) eg.push_back(i[0]);
`else
        for (int i = 0; i < 4; i++) eg.push_back(1'b0);
        for (int i = 0; i < 4; i++) eg.push_back(1'b1);
`endif
        wait_idle();

        // Port 1 arrives while port 0 is mid-transaction.
        bridge_extra = 3;
        mem[32'h600] = 32'h600D0000;
        mem[32'h680] = 32'h600D0001;
        eg.push_back(1'b0);
        eg.push_back(1'b1);
        rq[0].push_back(mk(32'h600, 32'h0, 2'd2, 1'b0, 32'h600D0000, 1'b1));
        wait_start(ok);
        #1 rq[1].push_back(mk(32'h680, 32'h0, 2'd2, 1'b0, 32'h600D0001, 1'b1));
        wait_idle();

        // Asynchronous reset during WAIT.
        bridge_extra = 20;
        eg.push_back(1'b1);
        rq[1].push_back(mk(32'h7000, 32'hFFFF0000, 2'd2, 1'b0, 32'h0, 1'b0));
        wait_start(ok);
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        check("arst_start", 32'(txn_start_o), 32'(0));
        check("arst_clear", 32'(txn_clear_ready_o), 32'(0));
        check("arst_done", 32'({done[0], done[1]}), 32'(0));
        check("arst_grant", 32'(grant_o), 32'(0));
        check("arst_txn_addr", txn_addr_o, 32'h0);
        check("arst_txn_data", txn_data_o, 32'h0);
        check("arst_txn_ctl", 32'({txn_size_o, txn_we_o}), 32'(0));
        check("arst_rdata0", rdata[0], 32'h0);
        check("arst_rdata1", rdata[1], 32'h0);
        @(posedge clk_i); #3;
        rst_ni = 1'b1;
        bridge_extra = 0;
        wait_idle();
        mem[32'h740] = 32'h0BADF00D;
        eg.push_back(1'b0);
        rq[0].push_back(mk(32'h740, 32'h0, 2'd2, 1'b0, 32'h0BADF00D, 1'b1));
        lat_check(0, 32'h0BADF00D);
        wait_idle();

        // Bridge keeps ready high one cycle past CLEAR; size 3 passes through untouched.
        bridge_lag = 1'b1;
        mem[32'h800] = 32'h11112222;
        mem[32'h900] = 32'h33334444;
        eg.push_back(1'b0);
        eg.push_back(1'b1);
        rq[0].push_back(mk(32'h800, 32'h0, 2'd2, 1'b0, 32'h11112222, 1'b1));
        rq[1].push_back(mk(32'h900, 32'h0, 2'd3, 1'b0, 32'h33334444, 1'b1));
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(posedge clk_i); #2;
            ok = done[0];
        end
        check("lag_done0_seen", 32'(ok), 32'(1));
        @(posedge clk_i); #2;
        check("lag_no_done", 32'({done[0], done[1]}), 32'(0));
        check("lag_no_clear", 32'(txn_clear_ready_o), 32'(0));
        check("lag_no_start", 32'(txn_start_o), 32'(0));
        wait_idle();
        bridge_lag = 1'b0;
        repeat (3) @(posedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
